id_decode_stage: RTL and testbench
==================================

Name: id_decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage with a valid/ready handshake on both sides, a 2-entry skid buffer and a synchronous flush. It sits between IF and EX. It extends combinational decode with:
- loads (read mem ops) and shifts
- LUI/AUIPC
- illegal-instruction flagging
- PC and rd pass-through

Parameters:
INSTR_W, `INSTR_W (32), instruction width
WORD_W, `WORD_W (32), datapath/immediate width; >= 32
ALU_OP_W, `ALU_OP_W, ALU op code width
PC_W, 32, program counter width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; registered
in_instr  in  INSTR_W  instruction word
in_pc  in  PC_W  PC of in_instr
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts
out_alu_op  out  ALU_OP_W  ALU operation
out_imm  out  WORD_W  sign/shift-extended immediate
out_alu_a_src  out  `ALU_SRC_A_W  ALU A source (XPR or PC)
out_alu_b_src  out  `ALU_SRC_B_W  ALU B source (XPR or IMM)
out_mem_op  out  `MEM_OP_W  memory operation
out_dest_src  out  `DEST_SRC_W  writeback source
out_rd  out  REG_ADDR_W  destination register
out_pc  out  PC_W  PC of decoded instruction
out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset (async, rst=1): state EMPTY, in_ready=1, out_valid=0. All data outputs 0, out_mem_op=`MEM_OP_NOP, out_dest_src=`DEST_SRC_NONE.
- Handshake rules:
  - Accept = in_valid & in_ready.
  - Retire = out_valid & out_ready.
  - Data and out_valid are stable while out_valid & !out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle. Throughput is 1/cycle.
- State machine (main register M drives outputs; skid register S):
  - EMPTY: accept -> ONE (M loaded).
  - ONE: accept & retire -> ONE (M reloaded). Accept & !retire -> TWO (S loaded). Retire & !accept -> EMPTY. Otherwise hold.
  - TWO: in_ready=0. Retire -> ONE (M<=S). Otherwise hold.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- Flush has priority over everything. Next state is EMPTY, out_valid=0, in_ready=1. An instruction accepted in the flush cycle is dropped.
- Ordering is strictly FIFO.
- Decode is performed once, at accept time; registers hold decoded fields.
- R-type:
  - A=XPR, B=XPR, dest=ALU, imm=0.
  - funct7 selects ADD/SUB and SRL/SRA.
  - Also decodes SLL, SLT, SLTU, XOR, OR, AND.
- I-type ALU:
  - imm = sign-extended imm12, B=IMM, dest=ALU.
  - SLLI/SRLI/SRAI: imm = zero-extended shamt[4:0]. funct7 other than 0x00/0x20 is illegal.
- Load:
  - imm = sign-extended imm12, op ADD, B=IMM, dest=MEM.
  - mem_op by funct3: LB/LH/LW/LBU/LHU -> `MEM_OP_RD_BYTE/HALF/WORD/BYTEU/HALFU.
  - Other funct3 is illegal.
- Store:
  - imm = sign-extended S-immediate, op ADD, B=IMM, dest=NONE, rd=0.
  - mem_op by funct3: SB/SH/SW -> WR_BYTE/HALF/WORD. Other funct3 is illegal.
- LUI: imm = {instr[31:12],12'b0} sign-extended; op ADD; A=ZERO; B=IMM; dest=ALU.
- AUIPC: as LUI but A=PC.
- Illegal (any other opcode or bad funct): out_illegal=1, mem_op=NOP, dest=NONE, rd=0, alu_op=ADD, imm=0. The entry still flows through the handshake.

Decomposition:
- Shared headers:
  - opcodes.vh: add OPCODE_LUI, OPCODE_AUIPC, FUNCT3 load codes, shift FUNCT7 codes, U-type imm macro.
  - alu_op.vh: add ALU_SLL, ALU_SRL, ALU_SRA.
  - mem_codes.vh: add MEM_OP_RD_* codes.
  - config.vh: add ALU_SRC_A_PC and ALU_SRC_A_ZERO.
- State encodings are localparams in this module.
- Sub-module id_decode_core: purely combinational. Maps instr to the decoded field bundle plus illegal. The stage instantiates it once on in_instr.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert rst with two entries held.
  - Required: out_valid=0 and in_ready=1 immediately; out_mem_op=NOP after reset.
- ALU and load decode:
  - Stimulus: addi x1,x2,-1 (0xFFF10093), then lw x5,8(x2) (0x00812283), out_ready=1.
  - Required: cycle+1: alu_op=ADD, imm=0xFFFFFFFF, B=IMM, dest=ALU, rd=1.
  - Required: cycle+2: imm=8, mem_op=RD_WORD, dest=MEM, rd=5.
- Store and LUI decode:
  - Stimulus: sw x5,-4(x2) (0xFE512E23), then lui x1,0x12345 (0x123450B7).
  - Required: store gives imm=0xFFFFFFFC, mem_op=WR_WORD, dest=NONE.
  - Required: LUI gives imm=0x12345000, A=ZERO, dest=ALU.
- Backpressure:
  - Stimulus: out_ready=0, offer 3 instructions back-to-back.
  - Required: first two accepted; in_ready=0 from cycle 2; third held upstream.
  - Required: releasing out_ready retires them in order, 1/cycle, no loss or duplication.
- Flush:
  - Stimulus: flush in state TWO, with in_valid=1 in the same cycle.
  - Required: next cycle out_valid=0, in_ready=1; the flush-cycle instruction never appears on the outputs.
- Illegal encodings:
  - Stimulus: opcode 0x7F; load with funct3=3; SLLI with funct7=0x20.
  - Required: out_illegal=1, mem_op=NOP, dest=NONE, out_valid=1, and out_pc matches in_pc.

Source files
------------

// File: rtl/id_decode_stage_pkg.sv
// Shared encodings for the ID stage: opcodes, funct codes, ALU ops, operand
// sources, memory ops and writeback sources.
package id_decode_stage_pkg;

    localparam int ALU_SRC_A_W = 2;
    localparam int ALU_SRC_B_W = 1;
    localparam int MEM_OP_W    = 4;
    localparam int DEST_SRC_W  = 2;
    localparam int ALU_ENC_W   = 4;

    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_LUI    = 7'h37;
    localparam logic [6:0] OPCODE_AUIPC  = 7'h17;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB  = 3'd0;
    localparam logic [2:0] FUNCT3_SH  = 3'd1;
    localparam logic [2:0] FUNCT3_SW  = 3'd2;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'd0;
    localparam logic [2:0] FUNCT3_SLL     = 3'd1;
    localparam logic [2:0] FUNCT3_SLT     = 3'd2;
    localparam logic [2:0] FUNCT3_SLTU    = 3'd3;
    localparam logic [2:0] FUNCT3_XOR     = 3'd4;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'd5;
    localparam logic [2:0] FUNCT3_OR      = 3'd6;
    localparam logic [2:0] FUNCT3_AND     = 3'd7;

    localparam logic [6:0] FUNCT7_NORMAL = 7'h00;
    localparam logic [6:0] FUNCT7_ALT    = 7'h20;

    typedef enum logic [ALU_ENC_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [ALU_SRC_A_W-1:0] {
        ALU_SRC_A_XPR  = 2'd0,
        ALU_SRC_A_PC   = 2'd1,
        ALU_SRC_A_ZERO = 2'd2
    } alu_src_a_e;

    typedef enum logic [ALU_SRC_B_W-1:0] {
        ALU_SRC_B_XPR = 1'b0,
        ALU_SRC_B_IMM = 1'b1
    } alu_src_b_e;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NOP      = 4'd0,
        MEM_OP_RD_BYTE  = 4'd1,
        MEM_OP_RD_HALF  = 4'd2,
        MEM_OP_RD_WORD  = 4'd3,
        MEM_OP_RD_BYTEU = 4'd4,
        MEM_OP_RD_HALFU = 4'd5,
        MEM_OP_WR_BYTE  = 4'd6,
        MEM_OP_WR_HALF  = 4'd7,
        MEM_OP_WR_WORD  = 4'd8
    } mem_op_e;

    typedef enum logic [DEST_SRC_W-1:0] {
        DEST_SRC_NONE = 2'd0,
        DEST_SRC_ALU  = 2'd1,
        DEST_SRC_MEM  = 2'd2
    } dest_src_e;

    // Base ALU op for a funct3 when funct7 is the normal encoding.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3);
        case (funct3)
            FUNCT3_ADD_SUB: return ALU_ADD;
            FUNCT3_SLL:     return ALU_SLL;
            FUNCT3_SLT:     return ALU_SLT;
            FUNCT3_SLTU:    return ALU_SLTU;
            FUNCT3_XOR:     return ALU_XOR;
            FUNCT3_SRL_SRA: return ALU_SRL;
            FUNCT3_OR:      return ALU_OR;
            default:        return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/id_decode_core.sv
// Purely combinational instruction decoder: maps one 32-bit instruction to the
// decoded control bundle and flags encodings it does not recognise.
module id_decode_core
    import id_decode_stage_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instr,
    output alu_op_e               alu_op,
    output logic [WORD_W-1:0]     imm,
    output alu_src_a_e            alu_a_src,
    output alu_src_b_e            alu_b_src,
    output mem_op_e               mem_op,
    output dest_src_e             dest_src,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        alu_op    = ALU_ADD;
        imm       = '0;
        alu_a_src = ALU_SRC_A_XPR;
        alu_b_src = ALU_SRC_B_XPR;
        mem_op    = MEM_OP_NOP;
        dest_src  = DEST_SRC_NONE;
        rd        = REG_ADDR_W'(instr[11:7]);
        illegal   = 1'b0;

        case (opcode)
            OPCODE_OP: begin
                dest_src = DEST_SRC_ALU;
                alu_op   = alu_from_funct3(funct3);
                if (funct7 == FUNCT7_ALT && funct3 == FUNCT3_ADD_SUB) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == FUNCT3_SRL_SRA) begin
                    alu_op = ALU_SRA;
                end else if (funct7 != FUNCT7_NORMAL) begin
                    illegal = 1'b1;
                end
            end
            OPCODE_OP_IMM: begin
                alu_b_src = ALU_SRC_B_IMM;
                dest_src  = DEST_SRC_ALU;
                alu_op    = alu_from_funct3(funct3);
                imm       = WORD_W'($signed(instr[31:20]));
                if (funct3 == FUNCT3_SLL) begin
                    imm     = WORD_W'(instr[24:20]);
                    illegal = (funct7 != FUNCT7_NORMAL);
                end else if (funct3 == FUNCT3_SRL_SRA) begin
                    imm = WORD_W'(instr[24:20]);
                    if (funct7 == FUNCT7_ALT) begin
                        alu_op = ALU_SRA;
                    end else if (funct7 != FUNCT7_NORMAL) begin
                        illegal = 1'b1;
                    end
                end
            end
            OPCODE_LOAD: begin
                alu_b_src = ALU_SRC_B_IMM;
                dest_src  = DEST_SRC_MEM;
                imm       = WORD_W'($signed(instr[31:20]));
                case (funct3)
                    FUNCT3_LB:  mem_op = MEM_OP_RD_BYTE;
                    FUNCT3_LH:  mem_op = MEM_OP_RD_HALF;
                    FUNCT3_LW:  mem_op = MEM_OP_RD_WORD;
                    FUNCT3_LBU: mem_op = MEM_OP_RD_BYTEU;
                    FUNCT3_LHU: mem_op = MEM_OP_RD_HALFU;
                    default:    illegal = 1'b1;
                endcase
            end
            OPCODE_STORE: begin
                alu_b_src = ALU_SRC_B_IMM;
                rd        = '0;
                imm       = WORD_W'($signed({instr[31:25], instr[11:7]}));
                case (funct3)
                    FUNCT3_SB: mem_op = MEM_OP_WR_BYTE;
                    FUNCT3_SH: mem_op = MEM_OP_WR_HALF;
                    FUNCT3_SW: mem_op = MEM_OP_WR_WORD;
                    default:   illegal = 1'b1;
                endcase
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                alu_a_src = (opcode == OPCODE_LUI) ? ALU_SRC_A_ZERO : ALU_SRC_A_PC;
                alu_b_src = ALU_SRC_B_IMM;
                dest_src  = DEST_SRC_ALU;
                imm       = WORD_W'($signed(imm_u(instr)));
            end
            default: illegal = 1'b1;
        endcase

        // An unrecognised encoding must not cause any architectural side effect.
        if (illegal) begin
            alu_op    = ALU_ADD;
            imm       = '0;
            alu_a_src = ALU_SRC_A_XPR;
            alu_b_src = ALU_SRC_B_XPR;
            mem_op    = MEM_OP_NOP;
            dest_src  = DEST_SRC_NONE;
            rd        = '0;
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered ID stage between IF and EX: decodes at accept time and holds up to
// two decoded entries (main + skid) behind a valid/ready handshake with flush.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int WORD_W     = 32,
    parameter int ALU_OP_W   = 4,
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ALU_OP_W-1:0]    out_alu_op,
    output logic [WORD_W-1:0]      out_imm,
    output logic [ALU_SRC_A_W-1:0] out_alu_a_src,
    output logic [ALU_SRC_B_W-1:0] out_alu_b_src,
    output logic [MEM_OP_W-1:0]    out_mem_op,
    output logic [DEST_SRC_W-1:0]  out_dest_src,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic                  illegal;
        alu_op_e               alu_op;
        logic [WORD_W-1:0]     imm;
        alu_src_a_e            alu_a_src;
        alu_src_b_e            alu_b_src;
        mem_op_e               mem_op;
        dest_src_e             dest_src;
        logic [REG_ADDR_W-1:0] rd;
        logic [PC_W-1:0]       pc;
    } entry_t;

    alu_op_e               dec_alu_op;
    logic [WORD_W-1:0]     dec_imm;
    alu_src_a_e            dec_alu_a_src;
    alu_src_b_e            dec_alu_b_src;
    mem_op_e               dec_mem_op;
    dest_src_e             dec_dest_src;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  dec_illegal;
    entry_t                dec;

    state_e state;
    entry_t main_q;
    entry_t skid_q;
    logic   accept;
    logic   retire;

    id_decode_core #(
        .WORD_W     (WORD_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_core (
        .instr     (in_instr[31:0]),
        .alu_op    (dec_alu_op),
        .imm       (dec_imm),
        .alu_a_src (dec_alu_a_src),
        .alu_b_src (dec_alu_b_src),
        .mem_op    (dec_mem_op),
        .dest_src  (dec_dest_src),
        .rd        (dec_rd),
        .illegal   (dec_illegal)
    );

    assign dec = '{
        illegal:   dec_illegal,
        alu_op:    dec_alu_op,
        imm:       dec_imm,
        alu_a_src: dec_alu_a_src,
        alu_b_src: dec_alu_b_src,
        mem_op:    dec_mem_op,
        dest_src:  dec_dest_src,
        rd:        dec_rd,
        pc:        in_pc
    };

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    // in_ready and out_valid are registered alongside the state so both ports
    // see flop outputs only.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the two entry registers are reset as well because their
            // contents drive the data outputs directly and must read 0/NOP.
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q    <= dec;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        main_q <= dec;
                    end else if (accept) begin
                        skid_q   <= dec;
                        state    <= ST_TWO;
                        in_ready <= 1'b0;
                    end else if (retire) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (retire) begin
                        main_q   <= skid_q;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_alu_op    = ALU_OP_W'(main_q.alu_op);
    assign out_imm       = main_q.imm;
    assign out_alu_a_src = main_q.alu_a_src;
    assign out_alu_b_src = main_q.alu_b_src;
    assign out_mem_op    = main_q.mem_op;
    assign out_dest_src  = main_q.dest_src;
    assign out_rd        = main_q.rd;
    assign out_pc        = main_q.pc;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed decode table, handshake
// corner sequences, and randomized traffic against a queue-based model.
module tb_id_decode_stage;
    import id_decode_stage_pkg::*;

    localparam int INSTR_W    = 32;
    localparam int WORD_W     = 32;
    localparam int ALU_OP_W   = 4;
    localparam int PC_W       = 32;
    localparam int REG_ADDR_W = 5;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_W-1:0]     in_instr;
    logic [PC_W-1:0]        in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [ALU_OP_W-1:0]    out_alu_op;
    logic [WORD_W-1:0]      out_imm;
    logic [ALU_SRC_A_W-1:0] out_alu_a_src;
    logic [ALU_SRC_B_W-1:0] out_alu_b_src;
    logic [MEM_OP_W-1:0]    out_mem_op;
    logic [DEST_SRC_W-1:0]  out_dest_src;
    logic [REG_ADDR_W-1:0]  out_rd;
    logic [PC_W-1:0]        out_pc;
    logic                   out_illegal;

    id_decode_stage #(
        .INSTR_W    (INSTR_W),
        .WORD_W     (WORD_W),
        .ALU_OP_W   (ALU_OP_W),
        .PC_W       (PC_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_imm       (out_imm),
        .out_alu_a_src (out_alu_a_src),
        .out_alu_b_src (out_alu_b_src),
        .out_mem_op    (out_mem_op),
        .out_dest_src  (out_dest_src),
        .out_rd        (out_rd),
        .out_pc        (out_pc),
        .out_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       illegal;
        logic [4:0] rd;
        logic [1:0] dest;
        logic [3:0] mem;
        logic       b;
        logic [1:0] a;
        logic [31:0] imm;
        logic [3:0] alu;
    } fields_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        fields_t     exp;
    } vec_t;

    typedef struct {
        fields_t     f;
        logic [31:0] pc;
    } ent_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic fields_t dut_fields();
        fields_t f;
        f.illegal = out_illegal;
        f.rd      = out_rd;
        f.dest    = out_dest_src;
        f.mem     = out_mem_op;
        f.b       = out_alu_b_src;
        f.a       = out_alu_a_src;
        f.imm     = out_imm;
        f.alu     = out_alu_op;
        return f;
    endfunction

    function automatic fields_t fld(input alu_op_e alu, input logic [31:0] imm,
                                    input alu_src_a_e a, input alu_src_b_e b,
                                    input mem_op_e mem, input dest_src_e dest,
                                    input logic [4:0] rd, input logic ill);
        fields_t f;
        f.illegal = ill;
        f.rd      = rd;
        f.dest    = dest;
        f.mem     = mem;
        f.b       = b;
        f.a       = a;
        f.imm     = imm;
        f.alu     = alu;
        return f;
    endfunction

    // Reference decoder built from the ISA rules with arithmetic on the word.
    function automatic fields_t ref_decode(input logic [31:0] ins);
        fields_t            f;
        logic [6:0]         opc   = ins[6:0];
        logic [2:0]         f3    = ins[14:12];
        logic [6:0]         f7    = ins[31:25];
        logic signed [31:0] s     = ins;
        logic [31:0]        i_imm = 32'(s >>> 20);
        logic [31:0]        s_imm = (i_imm & ~32'h1F) | ((ins >> 7) & 32'h1F);
        logic [31:0]        u_imm = ins & 32'hFFFFF000;
        logic [31:0]        shamt = (ins >> 20) & 32'h1F;
        bit                 ok    = 1'b1;
        bit                 shift;
        alu_op_e            base[8]   = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                          ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        mem_op_e            ld_map[8] = '{MEM_OP_RD_BYTE, MEM_OP_RD_HALF, MEM_OP_RD_WORD, MEM_OP_NOP,
                                          MEM_OP_RD_BYTEU, MEM_OP_RD_HALFU, MEM_OP_NOP, MEM_OP_NOP};
        mem_op_e            st_map[8] = '{MEM_OP_WR_BYTE, MEM_OP_WR_HALF, MEM_OP_WR_WORD, MEM_OP_NOP,
                                          MEM_OP_NOP, MEM_OP_NOP, MEM_OP_NOP, MEM_OP_NOP};
        f    = '0;
        f.rd = ins[11:7];
        if (opc == 7'h33) begin
            ok     = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            f.alu  = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : base[f3];
            f.dest = DEST_SRC_ALU;
        end else if (opc == 7'h13) begin
            shift  = (f3 == 3'd1) || (f3 == 3'd5);
            ok     = !shift || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
            f.alu  = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : base[f3];
            f.imm  = shift ? shamt : i_imm;
            f.b    = 1'b1;
            f.dest = DEST_SRC_ALU;
        end else if (opc == 7'h03) begin
            f.mem  = ld_map[f3];
            ok     = (ld_map[f3] != MEM_OP_NOP);
            f.imm  = i_imm;
            f.b    = 1'b1;
            f.dest = DEST_SRC_MEM;
        end else if (opc == 7'h23) begin
            f.mem  = st_map[f3];
            ok     = (st_map[f3] != MEM_OP_NOP);
            f.imm  = s_imm;
            f.b    = 1'b1;
            f.rd   = 5'd0;
        end else if (opc == 7'h37 || opc == 7'h17) begin
            f.imm  = u_imm;
            f.a    = (opc == 7'h37) ? ALU_SRC_A_ZERO : ALU_SRC_A_PC;
            f.b    = 1'b1;
            f.dest = DEST_SRC_ALU;
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            f         = '0;
            f.illegal = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  opcs[7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h00};
        int          k = $urandom_range(0, 6);
        int          sel = $urandom_range(0, 3);
        if (k < 6) r[6:0] = opcs[k];
        if (k < 2) r[31:25] = (sel == 0) ? 7'h20 : (sel == 1) ? r[31:25] : 7'h00;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    vec_t vecs[13];
    ent_t exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        bit   acc;
        bit   ret;

        vecs[0]  = '{"addi",   32'hFFF10093, 32'h1000, fld(ALU_ADD, 32'hFFFFFFFF, ALU_SRC_A_XPR, ALU_SRC_B_IMM, MEM_OP_NOP, DEST_SRC_ALU, 5'd1, 1'b0)};
        vecs[1]  = '{"lw",     32'h00812283, 32'h1004, fld(ALU_ADD, 32'h00000008, ALU_SRC_A_XPR, ALU_SRC_B_IMM, MEM_OP_RD_WORD, DEST_SRC_MEM, 5'd5, 1'b0)};
        vecs[2]  = '{"sw",     32'hFE512E23, 32'h1008, fld(ALU_ADD, 32'hFFFFFFFC, ALU_SRC_A_XPR, ALU_SRC_B_IMM, MEM_OP_WR_WORD, DEST_SRC_NONE, 5'd0, 1'b0)};
        vecs[3]  = '{"lui",    32'h123450B7, 32'h100C, fld(ALU_ADD, 32'h12345000, ALU_SRC_A_ZERO, ALU_SRC_B_IMM, MEM_OP_NOP, DEST_SRC_ALU, 5'd1, 1'b0)};
        vecs[4]  = '{"auipc",  32'h80000197, 32'h1010, fld(ALU_ADD, 32'h80000000, ALU_SRC_A_PC, ALU_SRC_B_IMM, MEM_OP_NOP, DEST_SRC_ALU, 5'd3, 1'b0)};
        vecs[5]  = '{"add",    32'h002081B3, 32'h1014, fld(ALU_ADD, 32'h0, ALU_SRC_A_XPR, ALU_SRC_B_XPR, MEM_OP_NOP, DEST_SRC_ALU, 5'd3, 1'b0)};
        vecs[6]  = '{"sub",    32'h402081B3, 32'h1018, fld(ALU_SUB, 32'h0, ALU_SRC_A_XPR, ALU_SRC_B_XPR, MEM_OP_NOP, DEST_SRC_ALU, 5'd3, 1'b0)};
        vecs[7]  = '{"sra",    32'h4020D233, 32'h101C, fld(ALU_SRA, 32'h0, ALU_SRC_A_XPR, ALU_SRC_B_XPR, MEM_OP_NOP, DEST_SRC_ALU, 5'd4, 1'b0)};
        vecs[8]  = '{"srai",   32'h4033D313, 32'h1020, fld(ALU_SRA, 32'h3, ALU_SRC_A_XPR, ALU_SRC_B_IMM, MEM_OP_NOP, DEST_SRC_ALU, 5'd6, 1'b0)};
        vecs[9]  = '{"lbu",    32'hFFF04383, 32'h1024, fld(ALU_ADD, 32'hFFFFFFFF, ALU_SRC_A_XPR, ALU_SRC_B_IMM, MEM_OP_RD_BYTEU, DEST_SRC_MEM, 5'd7, 1'b0)};
        vecs[10] = '{"ill_op", 32'h12345FFF, 32'h1028, fld(ALU_ADD, 32'h0, ALU_SRC_A_XPR, ALU_SRC_B_XPR, MEM_OP_NOP, DEST_SRC_NONE, 5'd0, 1'b1)};
        vecs[11] = '{"ill_ld", 32'h0081B283, 32'h102C, fld(ALU_ADD, 32'h0, ALU_SRC_A_XPR, ALU_SRC_B_XPR, MEM_OP_NOP, DEST_SRC_NONE, 5'd0, 1'b1)};
        vecs[12] = '{"ill_sl", 32'h40339313, 32'h1030, fld(ALU_ADD, 32'h0, ALU_SRC_A_XPR, ALU_SRC_B_XPR, MEM_OP_NOP, DEST_SRC_NONE, 5'd0, 1'b1)};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (2) step();
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_fields", dut_fields(), 0);
        check("reset_pc", out_pc, 0);
        rst = 1'b0;
        step();

        // Decode table, streamed back-to-back at full throughput.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            offer(vecs[i].instr, vecs[i].pc);
            step();
            check({"tbl_valid_", vecs[i].name}, out_valid, 1);
            check({"tbl_fields_", vecs[i].name}, dut_fields(), vecs[i].exp);
            check({"tbl_pc_", vecs[i].name}, out_pc, vecs[i].pc);
        end
        in_valid = 1'b0;
        step();
        check("tbl_drain", out_valid, 0);

        // Backpressure: two accepted, third held, then drained in order.
        out_ready = 1'b0;
        offer(vecs[0].instr, 32'h200);
        step();
        check("bp_acc1_ready", in_ready, 1);
        check("bp_acc1_pc", out_pc, 32'h200);
        offer(vecs[1].instr, 32'h204);
        step();
        check("bp_acc2_ready", in_ready, 0);
        check("bp_acc2_pc", out_pc, 32'h200);
        offer(vecs[2].instr, 32'h208);
        repeat (2) step();
        check("bp_hold_ready", in_ready, 0);
        check("bp_hold_pc", out_pc, 32'h200);
        check("bp_hold_fields", dut_fields(), vecs[0].exp);
        out_ready = 1'b1;
        step();
        check("bp_ret1_pc", out_pc, 32'h204);
        check("bp_ret1_fields", dut_fields(), vecs[1].exp);
        check("bp_ret1_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_ret2_pc", out_pc, 32'h208);
        check("bp_ret2_fields", dut_fields(), vecs[2].exp);
        step();
        check("bp_empty", out_valid, 0);

        // Flush while TWO entries are held.
        out_ready = 1'b0;
        offer(vecs[3].instr, 32'h300);
        step();
        offer(vecs[4].instr, 32'h304);
        step();
        flush = 1'b1;
        offer(vecs[5].instr, 32'h3F0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid", out_valid, 0);
        check("fl2_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("fl2_after", out_valid, 0);

        // Flush in ONE with an instruction accepted in the same cycle.
        offer(vecs[6].instr, 32'h400);
        step();
        flush = 1'b1;
        offer(vecs[7].instr, 32'h4F0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl1_valid", out_valid, 0);
        check("fl1_ready", in_ready, 1);
        step();
        check("fl1_after", out_valid, 0);

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        offer(vecs[1].instr, 32'h500);
        step();
        offer(vecs[9].instr, 32'h504);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_ready", in_ready, 1);
        check("rstmid_mem", out_mem_op, MEM_OP_NOP);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rstmid_post_mem", out_mem_op, MEM_OP_NOP);
        check("rstmid_post_valid", out_valid, 0);

        // Randomized traffic against the FIFO-of-two model.
        exp_q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            acc = in_valid && (exp_q.size() < 2);
            ret = out_ready && (exp_q.size() > 0);
            step();
            if (flush) begin
                exp_q.delete();
            end else begin
                if (ret) void'(exp_q.pop_front());
                if (acc) begin
                    e.f  = ref_decode(in_instr);
                    e.pc = in_pc;
                    exp_q.push_back(e);
                end
            end
            check("rnd_valid", out_valid, (exp_q.size() > 0));
            check("rnd_ready", in_ready, (exp_q.size() < 2));
            if (exp_q.size() > 0) begin
                check("rnd_fields", dut_fields(), exp_q[0].f);
                check("rnd_pc", out_pc, exp_q[0].pc);
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
